// File: rtl/fruit_ninja_pkg.sv
// Shared types and constants for the PS/2 mouse front end.
package fruit_ninja_pkg;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    PK_WAIT_B0 = 2'd0,
    PK_WAIT_B1 = 2'd1,
    PK_WAIT_B2 = 2'd2,
    PK_UPDATE  = 2'd3
  } pkt_state_t;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned ALIGN = 3;
  localparam int unsigned XSIGN = 4;
  localparam int unsigned YSIGN = 5;
  localparam int unsigned XOVF  = 6;
  localparam int unsigned YOVF  = 7;

  localparam int unsigned PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_mouse_cursor_if.sv
// PS/2 line inputs and cursor outputs of the mouse front end.
interface ps2_mouse_cursor_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] mouse_x;
  logic [7:0] mouse_y;
  logic       mouse_click;
  logic       click_pulse;
  logic       packet_valid;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  mouse_x, mouse_y, mouse_click, click_pulse, packet_valid, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output mouse_x, mouse_y, mouse_click, click_pulse, packet_valid, frame_error
  );
endinterface

// File: rtl/ps2_mouse_cursor_rx_byte.sv
// PS/2 byte receiver: synchronizer, falling-edge detect, 11-bit deframer, idle timeout.
module ps2_rx_byte
  import fruit_ninja_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_error
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  logic          r_clk_s1, r_clk_s2, r_clk_prev;
  logic          r_data_s1, r_data_s2;
  frame_state_t  r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_frame_error;
  logic [CW-1:0] r_idle_cnt;
  logic          w_fall;

  assign w_fall = r_clk_prev & ~r_clk_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Lines idle high, so the synchronizers start high to avoid a false edge.
      r_clk_s1      <= 1'b1;
      r_clk_s2      <= 1'b1;
      r_clk_prev    <= 1'b1;
      r_data_s1     <= 1'b1;
      r_data_s2     <= 1'b1;
      r_state       <= FR_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_byte        <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_idle_cnt    <= '0;
    end else begin
      r_clk_s1      <= i_ps2_clk;
      r_clk_s2      <= r_clk_s1;
      r_clk_prev    <= r_clk_s2;
      r_data_s1     <= i_ps2_data;
      r_data_s2     <= r_data_s1;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;

      if (w_fall) begin
        r_idle_cnt <= '0;
        case (r_state)
          FR_IDLE: begin
            if (!r_data_s2) begin
              r_state   <= FR_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_error <= 1'b1;
            end
          end
          FR_DATA: begin
            r_shift <= {r_data_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_state <= FR_PARITY;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          FR_PARITY: begin
            r_parity <= r_data_s2;
            r_state  <= FR_STOP;
          end
          FR_STOP: begin
            r_state <= FR_IDLE;
            if (r_data_s2 && (^{r_shift, r_parity})) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_error <= 1'b1;
            end
          end
          default: r_state <= FR_IDLE;
        endcase
      end else if (r_state != FR_IDLE) begin
        if (r_idle_cnt == TO_VAL) begin
          r_frame_error <= 1'b1;
          r_state       <= FR_IDLE;
          r_idle_cnt    <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign o_byte_valid  = r_byte_valid;
  assign o_byte_data   = r_byte;
  assign o_frame_error = r_frame_error;

endmodule

// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse packet assembly and clamped cursor integration in game coordinates.
module ps2_mouse_cursor
  import fruit_ninja_pkg::*;
#(
  parameter int unsigned X_MAX          = 159,
  parameter int unsigned Y_MAX          = 119,
  parameter int unsigned SPEED_SHIFT    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_mouse_cursor_if.slave bus
);

  localparam logic [7:0]        X_MAX_8 = 8'(X_MAX);
  localparam logic [7:0]        Y_MAX_8 = 8'(Y_MAX);
  localparam logic signed [9:0] X_MAX_S = 10'(X_MAX);
  localparam logic signed [9:0] Y_MAX_S = 10'(Y_MAX);
  localparam logic [7:0]        X_RST   = 8'((X_MAX + 1) / 2);
  localparam logic [7:0]        Y_RST   = 8'((Y_MAX + 1) / 2);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_frame_error;

  ps2_rx_byte #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_frame_error(w_frame_error)
  );

  pkt_state_t r_state;
  logic       r_btn, r_xs, r_ys, r_xo, r_yo;
  logic [7:0] r_b1, r_b2;
  logic [7:0] r_x, r_y;
  logic       r_click, r_click_pulse, r_packet_valid;

  logic signed [8:0] w_dx, w_dy, w_sx, w_sy;
  logic signed [9:0] w_sum_x, w_sum_y;
  logic [7:0]        w_next_x, w_next_y;

  always_comb begin
    w_dx    = {r_xs, r_b1};
    w_dy    = {r_ys, r_b2};
    w_sx    = w_dx >>> SPEED_SHIFT;
    w_sy    = w_dy >>> SPEED_SHIFT;
    // PS/2 Y is up-positive; the screen is down-positive, hence the subtraction.
    w_sum_x = $signed({2'b00, r_x}) + $signed({w_sx[8], w_sx});
    w_sum_y = $signed({2'b00, r_y}) - $signed({w_sy[8], w_sy});

    w_next_x = w_sum_x[7:0];
    if (w_sum_x[9])             w_next_x = '0;
    else if (w_sum_x > X_MAX_S) w_next_x = X_MAX_8;

    w_next_y = w_sum_y[7:0];
    if (w_sum_y[9])             w_next_y = '0;
    else if (w_sum_y > Y_MAX_S) w_next_y = Y_MAX_8;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= PK_WAIT_B0;
      r_btn          <= 1'b0;
      r_xs           <= 1'b0;
      r_ys           <= 1'b0;
      r_xo           <= 1'b0;
      r_yo           <= 1'b0;
      r_b1           <= '0;
      r_b2           <= '0;
      r_x            <= X_RST;
      r_y            <= Y_RST;
      r_click        <= 1'b0;
      r_click_pulse  <= 1'b0;
      r_packet_valid <= 1'b0;
    end else begin
      r_click_pulse  <= 1'b0;
      r_packet_valid <= 1'b0;
      if (w_frame_error) begin
        r_state <= PK_WAIT_B0;
      end else begin
        case (r_state)
          PK_WAIT_B0: begin
            if (w_byte_valid && w_byte_data[ALIGN]) begin
              r_btn   <= w_byte_data[BTN_L];
              r_xs    <= w_byte_data[XSIGN];
              r_ys    <= w_byte_data[YSIGN];
              r_xo    <= w_byte_data[XOVF];
              r_yo    <= w_byte_data[YOVF];
              r_state <= PK_WAIT_B1;
            end
          end
          PK_WAIT_B1: begin
            if (w_byte_valid) begin
              r_b1    <= w_byte_data;
              r_state <= PK_WAIT_B2;
            end
          end
          PK_WAIT_B2: begin
            if (w_byte_valid) begin
              r_b2    <= w_byte_data;
              r_state <= PK_UPDATE;
            end
          end
          PK_UPDATE: begin
            if (!r_xo) r_x <= w_next_x;
            if (!r_yo) r_y <= w_next_y;
            r_click        <= r_btn;
            r_click_pulse  <= ~r_click & r_btn;
            r_packet_valid <= 1'b1;
            r_state        <= PK_WAIT_B0;
          end
          default: r_state <= PK_WAIT_B0;
        endcase
      end
    end
  end

  assign bus.mouse_x      = r_x;
  assign bus.mouse_y      = r_y;
  assign bus.mouse_click  = r_click;
  assign bus.click_pulse  = r_click_pulse;
  assign bus.packet_valid = r_packet_valid;
  assign bus.frame_error  = w_frame_error;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor: packet vector table plus framing corner cases.
module tb_ps2_mouse_cursor;

  localparam int unsigned TB_TIMEOUT = 400;
  localparam int unsigned HALF       = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_mouse_cursor_if bus();

  ps2_mouse_cursor #(
    .X_MAX(159),
    .Y_MAX(119),
    .SPEED_SHIFT(1),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned pv_cnt = 0, cp_cnt = 0, fe_cnt = 0;

  always @(negedge clk) begin
    if (bus.packet_valid) pv_cnt++;
    if (bus.click_pulse)  cp_cnt++;
    if (bus.frame_error)  fe_cnt++;
  end

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int unsigned ex, ey;
    int unsigned ec, ecp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(1'b1);
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, b1, b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_partial();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
  endtask

  initial begin
    int unsigned pv0, cp0, fe0;

    vecs[0]  = '{8'h09, 8'h0A, 8'h05,  85,  58, 1, 1};
    vecs[1]  = '{8'h09, 8'h00, 8'h00,  85,  58, 1, 0};
    vecs[2]  = '{8'h18, 8'h00, 8'h00,   0,  58, 0, 0};
    vecs[3]  = '{8'h08, 8'hFF, 8'h00, 127,  58, 0, 0};
    vecs[4]  = '{8'h08, 8'hFF, 8'h00, 159,  58, 0, 0};
    vecs[5]  = '{8'h08, 8'hFF, 8'h00, 159,  58, 0, 0};
    vecs[6]  = '{8'h18, 8'hFF, 8'h00, 158,  58, 0, 0};
    vecs[7]  = '{8'h48, 8'h80, 8'h14, 158,  48, 0, 0};
    vecs[8]  = '{8'h28, 8'h00, 8'hEC, 158,  58, 0, 0};
    vecs[9]  = '{8'h08, 8'h00, 8'hF0, 158,   0, 0, 0};
    vecs[10] = '{8'h28, 8'h00, 8'h00, 158, 119, 0, 0};
    vecs[11] = '{8'h89, 8'h00, 8'h05, 158, 119, 1, 1};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset        = 1'b1;
    repeat (5) @(posedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("reset_x", bus.mouse_x, 80);
    chk("reset_y", bus.mouse_y, 60);
    chk("reset_click", bus.mouse_click, 0);
    chk("reset_pulses", pv_cnt + cp_cnt + fe_cnt, 0);

    for (int i = 0; i < 12; i++) begin
      pv0 = pv_cnt; cp0 = cp_cnt; fe0 = fe_cnt;
      send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      chk($sformatf("v%0d_x", i), bus.mouse_x, vecs[i].ex);
      chk($sformatf("v%0d_y", i), bus.mouse_y, vecs[i].ey);
      chk($sformatf("v%0d_click", i), bus.mouse_click, vecs[i].ec);
      chk($sformatf("v%0d_cpulse", i), cp_cnt - cp0, vecs[i].ecp);
      chk($sformatf("v%0d_pvalid", i), pv_cnt - pv0, 1);
      chk($sformatf("v%0d_ferr", i), fe_cnt - fe0, 0);
    end

    // Bad parity on byte 1 drops the packet; the next one decodes.
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h0A, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("par_ferr", fe_cnt - fe0, 1);
    chk("par_pvalid", pv_cnt - pv0, 0);
    chk("par_x_hold", bus.mouse_x, 158);
    send_packet(8'h08, 8'h02, 8'h00);
    chk("par_next_pvalid", pv_cnt - pv0, 1);
    chk("par_next_x", bus.mouse_x, 159);
    chk("par_next_click", bus.mouse_click, 0);

    // Misaligned stray byte is discarded.
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h00, 1'b0);
    send_packet(8'h18, 8'hFC, 8'h00);
    chk("stray_pvalid", pv_cnt - pv0, 1);
    chk("stray_x", bus.mouse_x, 157);
    chk("stray_y", bus.mouse_y, 119);
    chk("stray_ferr", fe_cnt - fe0, 0);

    // Start bit of 1 is a framing error.
    fe0 = fe_cnt;
    send_bit(1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("start_ferr", fe_cnt - fe0, 1);

    // Partial frame aborted by idle timeout, then recovery.
    fe0 = fe_cnt; pv0 = pv_cnt;
    send_partial();
    repeat (TB_TIMEOUT / 2) @(posedge clk);
    @(negedge clk);
    chk("to_early", fe_cnt - fe0, 0);
    repeat (TB_TIMEOUT) @(posedge clk);
    @(negedge clk);
    chk("to_ferr", fe_cnt - fe0, 1);
    chk("to_pvalid", pv_cnt - pv0, 0);
    send_packet(8'h08, 8'h00, 8'h02);
    chk("to_next_pvalid", pv_cnt - pv0, 1);
    chk("to_next_y", bus.mouse_y, 118);

    // Reset mid-frame restores the centre and decoding resumes.
    send_partial();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_x", bus.mouse_x, 80);
    chk("rst_mid_y", bus.mouse_y, 60);
    chk("rst_mid_click", bus.mouse_click, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    fe0 = fe_cnt; pv0 = pv_cnt; cp0 = cp_cnt;
    send_packet(8'h09, 8'h0A, 8'h05);
    chk("rst_next_x", bus.mouse_x, 85);
    chk("rst_next_y", bus.mouse_y, 58);
    chk("rst_next_click", bus.mouse_click, 1);
    chk("rst_next_cpulse", cp_cnt - cp0, 1);
    chk("rst_next_pvalid", pv_cnt - pv0, 1);
    chk("rst_next_ferr", fe_cnt - fe0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
